cn_explode: RTL and testbench

// - Scratchpad initializer ("explode") for the CryptoNight pipeline; runs directly upstream of the main loop.
// - Takes 8x128-bit text blocks (Keccak state bytes 64..191) and 10 pre-expanded AES round keys.
// - Repeatedly encrypts the 8 blocks (10 rounds each, chained) and writes each result group of 8 words to table RAM.
// - Drives the shared single-round AES engine and the table RAM write port; the main loop owns both after sts_finished.

---
 rtl/cn_explode_pkg.sv | 24 ++
 rtl/cn_explode_if.sv | 33 +++
 rtl/cn_explode.sv | 131 +++++++++++++
 tb/tb_cn_explode.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cn_explode_pkg.sv
// CryptoNight explode shared definitions: loop dimensions, FSM states
// and the fill-size helper used by the explode and the main loop.
package cn_explode_pkg;

    // Scratchpad shrink factor (log2) applied when mode_speedup is set.
    localparam int CFG_SPEEDUP_IL_LOG2 = 4;

    localparam int CN_AES_ROUNDS    = 10;
    localparam int CN_EXPLODE_LANES = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } explode_state_t;

    // log2 of the number of table words filled for a given address width.
    function automatic int fill_log2(input int aw, input logic speedup);
        return speedup ? (aw - CFG_SPEEDUP_IL_LOG2) : aw;
    endfunction

endpackage

// File: rtl/cn_explode_if.sv
// Explode datapath bus: table RAM write port plus the shared AES round.
// master = explode side (drives RAM and round inputs), slave = RAM/AES side.
interface cn_explode_if #(
    parameter int ADDR_WIDTH = 17
) ();

    logic                  ram_wren;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [127:0]          ram_wrdata;

    logic [127:0]          cipher_StateIn;
    logic [127:0]          cipher_Roundkey;
    logic [127:0]          cipher_StateOut;

    modport master (
        output ram_wren,
        output ram_addr,
        output ram_wrdata,
        output cipher_StateIn,
        output cipher_Roundkey,
        input  cipher_StateOut
    );

    modport slave (
        input  ram_wren,
        input  ram_addr,
        input  ram_wrdata,
        input  cipher_StateIn,
        input  cipher_Roundkey,
        output cipher_StateOut
    );

endinterface

// File: rtl/cn_explode.sv
// CryptoNight scratchpad initializer: 8 lanes x 10 AES rounds per group,
// each group written to table RAM as 8 words, chained until the table is full.
// Ports: clk, reset (async, active high), ctrl_start (rising edge starts),
//   sts_running/sts_finished status, in_keys (10 round keys), in_text
//   (8 initial blocks), mode_speedup (short fill), bus (RAM + AES round).
module cn_explode
    import cn_explode_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ctrl_start,
    output logic          sts_running,
    output logic          sts_finished,
    input  logic [1279:0] in_keys,
    input  logic [1023:0] in_text,
    input  logic          mode_speedup,
    cn_explode_if.master  bus
);

    localparam logic [2:0] LAST_LANE  = 3'(CN_EXPLODE_LANES - 1);
    localparam logic [3:0] LAST_ROUND = 4'(CN_AES_ROUNDS - 1);

    localparam int FAST_LOG2 = fill_log2(ADDR_WIDTH, 1'b1);

    localparam logic [ADDR_WIDTH-1:0] LAST_FULL = '1;
    localparam logic [ADDR_WIDTH-1:0] LAST_FAST =
        ADDR_WIDTH'((64'd1 << FAST_LOG2) - 64'd1);

    explode_state_t        state;
    explode_state_t        state_nxt;
    logic [127:0]          text [CN_EXPLODE_LANES];
    logic [127:0]          rkey [CN_AES_ROUNDS];
    logic [2:0]            lane;
    logic [3:0]            round;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  st_d;
    logic                  start;
    logic                  lane_last;
    logic                  round_last;
    logic                  addr_last;
    logic                  wren_q;

    always_comb begin
        for (int i = 0; i < CN_AES_ROUNDS; i++) begin
            rkey[i] = in_keys[128*i +: 128];
        end
    end

    assign start      = ctrl_start & ~st_d;
    assign lane_last  = (lane == LAST_LANE);
    assign round_last = (round == LAST_ROUND);
    assign last_addr  = mode_speedup ? LAST_FAST : LAST_FULL;
    assign addr_last  = (addr == last_addr);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE,
            ST_DONE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_ROUND;
            ST_ROUND: if (lane_last && round_last) state_nxt = ST_WRITE;
            ST_WRITE: begin
                if (lane_last) begin
                    state_nxt = addr_last ? ST_DONE : ST_ROUND;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Status and write strobe are registered from the next state so they
    // change only on clock edges and never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            st_d         <= 1'b0;
            lane         <= '0;
            round        <= '0;
            addr         <= '0;
            wren_q       <= 1'b0;
            sts_running  <= 1'b0;
            sts_finished <= 1'b0;
            for (int l = 0; l < CN_EXPLODE_LANES; l++) begin
                text[l] <= '0;
            end
        end else begin
            st_d         <= ctrl_start;
            state        <= state_nxt;
            wren_q       <= (state_nxt == ST_WRITE);
            sts_finished <= (state_nxt == ST_DONE);
            sts_running  <= (state_nxt == ST_LOAD) ||
                            (state_nxt == ST_ROUND) ||
                            (state_nxt == ST_WRITE);
            unique case (state)
                ST_LOAD: begin
                    for (int l = 0; l < CN_EXPLODE_LANES; l++) begin
                        text[l] <= in_text[128*l +: 128];
                    end
                    lane  <= '0;
                    round <= '0;
                    addr  <= '0;
                end
                ST_ROUND: begin
                    text[lane] <= bus.cipher_StateOut;
                    lane       <= lane + 3'd1;
                    if (lane_last) begin
                        round <= round_last ? 4'd0 : round + 4'd1;
                    end
                end
                ST_WRITE: begin
                    lane <= lane + 3'd1;
                    // Hold at the final address so the counter never wraps.
                    if (!(lane_last && addr_last)) begin
                        addr <= addr + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_wren        = wren_q;
    assign bus.ram_addr        = addr;
    assign bus.ram_wrdata      = text[lane];
    assign bus.cipher_StateIn  = text[lane];
    assign bus.cipher_Roundkey = rkey[round];

endmodule

// File: tb/tb_cn_explode.sv
// Directed bench for cn_explode: behavioural AES round, software explode
// model and RAM image capture, with ADDR_WIDTH = 7.
module tb_cn_explode;
    import cn_explode_pkg::*;

    localparam int AW    = 7;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          ctrl_start;
    logic          sts_running;
    logic          sts_finished;
    logic [1279:0] in_keys;
    logic [1023:0] in_text;
    logic          mode_speedup;

    cn_explode_if #(.ADDR_WIDTH(AW)) bus ();

    cn_explode #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ctrl_start   (ctrl_start),
        .sts_running  (sts_running),
        .sts_finished (sts_finished),
        .in_keys      (in_keys),
        .in_text      (in_text),
        .mode_speedup (mode_speedup),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n      = 0;
    int wcount = 0;
    int max_addr = -1;
    int model_words = 0;
    logic [127:0] mem     [WORDS];
    logic [127:0] exp_mem [WORDS];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= x;
            x = xt(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        logic [15:0] d = {x, x} << k;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s = b;
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    // One aesenc-style round; byte 0 of the state sits in bits [7:0].
    function automatic logic [127:0] aes_round(input logic [127:0] st,
                                               input logic [127:0] k);
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r + 4*c] = sbox(st[8*(r + 4*((c + r) % 4)) +: 8]);
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            o[32*c +: 8]      = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[32*c + 24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o ^ k;
    endfunction

    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
        return y;
    endfunction

    assign bus.cipher_StateOut = aes_round(bus.cipher_StateIn, bus.cipher_Roundkey);

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_model(input logic speedup);
        logic [127:0] t [8];
        model_words = 1 << fill_log2(AW, speedup);
        for (int i = 0; i < WORDS; i++) exp_mem[i] = '0;
        for (int l = 0; l < 8; l++) t[l] = in_text[128*l +: 128];
        for (int g = 0; g < model_words / 8; g++) begin
            for (int r = 0; r < 10; r++)
                for (int l = 0; l < 8; l++)
                    t[l] = aes_round(t[l], in_keys[128*r +: 128]);
            for (int l = 0; l < 8; l++) exp_mem[8*g + l] = t[l];
        end
    endtask

    // Every cycle passes through here; RAM writes are captured mid-cycle.
    task automatic tick();
        @(negedge clk);
        if (bus.ram_wren) begin
            mem[bus.ram_addr] = bus.ram_wrdata;
            wcount++;
            if (int'(bus.ram_addr) > max_addr) max_addr = int'(bus.ram_addr);
        end
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic tick_to(input int k);
        while (n < k) tick();
    endtask

    task automatic do_start();
        ctrl_start = 1'b1;
        tick();
        n = 0;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
        wcount   = 0;
        max_addr = -1;
    endtask

    task automatic wait_finish(input string tag, input int exp_n);
        while (!sts_finished && n < exp_n + 20) tick();
        check(tag, n, exp_n);
    endtask

    task automatic cmp_image(input string tag);
        int bad = 0;
        for (int i = 0; i < WORDS; i++)
            if (mem[i] !== exp_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    logic [127:0] fips_rk [10];
    localparam int G_FULL = WORDS / 8;
    localparam int FAST_W = 1 << (AW - CFG_SPEEDUP_IL_LOG2);

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        fips_rk[0] = 128'h000102030405060708090a0b0c0d0e0f;
        fips_rk[1] = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        fips_rk[2] = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        fips_rk[3] = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        fips_rk[4] = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        fips_rk[5] = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        fips_rk[6] = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        fips_rk[7] = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        fips_rk[8] = 128'h47438735a41c65b9e016baf4aebf7ad2;
        fips_rk[9] = 128'h549932d1f08557681093ed9cbe2c974e;

        reset = 1'b1; ctrl_start = 1'b0; mode_speedup = 1'b0;
        in_keys = '0; in_text = '0;
        clear_ram();
        tick(); tick();
        check("rst_running", sts_running, 0);
        check("rst_finished", sts_finished, 0);
        check("rst_wren", bus.ram_wren, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_wrdata", bus.ram_wrdata, 0);
        reset = 1'b0;
        tick();

        // Round model against FIPS-197 C.1 round 1 -> round 2 start.
        check("aes_kat",
              aes_round(bswap(128'h00102030405060708090a0b0c0d0e0f0), bswap(fips_rk[1])),
              bswap(128'h89d810e8855ace682d1843d8cb128fe4));

        // Zero text, zero keys, full fill.
        run_model(1'b0);
        do_start();
        ctrl_start = 1'b0;
        check("zero_load_running", sts_running, 1);
        tick_to(80);
        check("zero_wren_t81", bus.ram_wren, 0);
        tick_to(81);
        check("zero_wren_t82", bus.ram_wren, 1);
        check("zero_addr0", bus.ram_addr, 0);
        check("zero_word0", bus.ram_wrdata, exp_mem[0]);
        tick_to(88 * G_FULL);
        check("zero_not_done_early", sts_finished, 0);
        wait_finish("zero_done_cycle", 1 + 88 * G_FULL);
        check("zero_running_off", sts_running, 0);
        check("zero_wcount", wcount, WORDS);
        cmp_image("zero_image");

        // FIPS keys and text, speedup fill, started from DONE.
        for (int r = 0; r < 10; r++) in_keys[128*r +: 128] = bswap(fips_rk[r]);
        in_text[127:0] = bswap(128'h00112233445566778899aabbccddeeff);
        for (int l = 1; l < 8; l++) in_text[128*l +: 128] = {16{8'(l * 17 + 3)}};
        mode_speedup = 1'b1;
        run_model(1'b1);
        tick();
        clear_ram();
        do_start();
        ctrl_start = 1'b0;
        check("fips_fin_drop", sts_finished, 0);
        check("fips_running", sts_running, 1);
        tick_to(1);
        check("fips_statein_r0", bus.cipher_StateIn, in_text[127:0]);
        check("fips_rkey_r0", bus.cipher_Roundkey, bswap(fips_rk[0]));
        tick_to(9);
        check("fips_statein_r1", bus.cipher_StateIn,
              aes_round(in_text[127:0], bswap(fips_rk[0])));
        check("fips_rkey_r1", bus.cipher_Roundkey, bswap(fips_rk[1]));
        tick_to(81);
        check("fips_wren_t82", bus.ram_wren, 1);
        check("fips_addr0", bus.ram_addr, 0);
        check("fips_word0", bus.ram_wrdata, exp_mem[0]);
        wait_finish("fast_done_cycle", 89);
        check("fast_wcount", wcount, FAST_W);
        check("fast_max_addr", max_addr, FAST_W - 1);
        cmp_image("fast_image");

        // Start held high: one fill only; a fresh edge refills identically.
        tick();
        clear_ram();
        do_start();
        tick_to(2000);
        check("hold_finished", sts_finished, 1);
        check("hold_wcount", wcount, FAST_W);
        ctrl_start = 1'b0;
        tick();
        clear_ram();
        do_start();
        ctrl_start = 1'b0;
        check("restart_fin_drop", sts_finished, 0);
        wait_finish("restart_done_cycle", 89);
        cmp_image("restart_image");

        // Start pulses during ROUND and WRITE are ignored.
        mode_speedup = 1'b0;
        run_model(1'b0);
        tick();
        clear_ram();
        do_start();
        ctrl_start = 1'b0;
        tick_to(40); ctrl_start = 1'b1;
        tick_to(42); ctrl_start = 1'b0;
        tick_to(83); ctrl_start = 1'b1;
        tick_to(85); ctrl_start = 1'b0;
        wait_finish("pulse_done_cycle", 1 + 88 * G_FULL);
        check("pulse_wcount", wcount, WORDS);
        cmp_image("pulse_image");

        // Reset mid-fill, then a clean restart.
        tick();
        clear_ram();
        do_start();
        ctrl_start = 1'b0;
        tick_to(50);
        reset = 1'b1;
        tick();
        check("mid_rst_running", sts_running, 0);
        check("mid_rst_finished", sts_finished, 0);
        check("mid_rst_wren", bus.ram_wren, 0);
        check("mid_rst_addr", bus.ram_addr, 0);
        check("mid_rst_wrdata", bus.ram_wrdata, 0);
        tick(); tick();
        reset = 1'b0;
        check("mid_rst_no_writes", wcount, 0);
        tick();
        clear_ram();
        do_start();
        ctrl_start = 1'b0;
        wait_finish("post_rst_done_cycle", 1 + 88 * G_FULL);
        check("post_rst_wcount", wcount, WORDS);
        cmp_image("post_rst_image");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
